buffer_f_d_skid: RTL and testbench
==================================

// Module: buffer_F_D_skid
// PURPOSE
//  Fetch->Decode pipeline buffer, directly upstream of the D/E control/data buffers.
//  Two-entry skid buffer (main + skid) with valid/ready handshake on both sides and a flush input.
//  Breaks every combinational path between fetch and decode (data, valid, ready), at full throughput.
// PARAMETERS
//  XLEN      32            width of pc and pcplus4
//  ILEN      32            instruction width
//  NOP_INST  32'h00000013  value of inst_D while no valid entry (addi x0,x0,0)
// PORTS
//  clk          in   1     clock, rising edge
//  rst          in   1     asynchronous, active-high reset
//  valid_F      in   1     fetch presents an instruction
//  ready_F      out  1     buffer can accept; registered, equals !skid_valid
//  inst_F       in   ILEN  fetched instruction
//  pc_F         in   XLEN  pc of inst_F
//  pcplus4_F    in   XLEN  pc_F+4
//  valid_D      out  1     main entry valid toward decode
//  ready_D      in   1     decode accepts (low = hazard stall)
//  inst_D       out  ILEN  main entry instruction (NOP_INST when !valid_D)
//  pc_D         out  XLEN  main entry pc
//  pcplus4_D    out  XLEN  main entry pc+4
//  flush        in   1     redirect from E (taken branch/jump): drop all held and incoming
// BEHAVIOUR
//  - Reset (async): valid_D=0, skid_valid=0, ready_F=1, inst_D=NOP_INST, pc_D=0, pcplus4_D=0, skid data=0.
//  - acc = valid_F & ready_F; deq = valid_D & ready_D; all updates on rising clk.
//  - States {EMPTY, ONE, FULL} = (valid_D, skid_valid) in {00, 10, 11}; 01 is illegal, never reached.
//  - EMPTY: acc -> main<=in, ONE.
//  - ONE: acc&deq -> main<=in, ONE; acc&!deq -> skid<=in, FULL;
//         !acc&deq -> EMPTY; idle -> hold.
//  - FULL: ready_F=0, so no acc. deq -> main<=skid, ONE; else hold.
//  - flush has priority over all: next state EMPTY, inst_D<=NOP_INST.
//    An instruction accepted in the same cycle is discarded. ready_F=1 the cycle after.
//    Flush during FULL drops both entries.
//  - Latency: 1 cycle valid_F -> valid_D. Throughput: 1 instr/cycle when ready_D held high.
//  - Strict FIFO order; no entry duplicated or lost except by flush.
//  - Outputs come only from flops. ready_F never depends combinationally on ready_D.
//  - Data regs load only on an accept/move event (no toggling while holding).
//  - rst asserted mid-transfer: state forced to EMPTY immediately; held entries lost.
// CONFIGURATION
//  IFID_PERF_CNT_EN defined: adds outputs stall_cnt[31:0] and flush_cnt[31:0].
//   - stall_cnt: +1 each cycle valid_D & !ready_D.
//   - flush_cnt: +1 each cycle flush=1.
//   - Both wrap at 2^32 and reset to 0.
//  Undefined: ports and counters absent; behaviour otherwise identical.
// STRUCTURE
//  Shared package pipe_pkg:
//   - typedef if_id_payload_t {inst, pc, pcplus4}
//   - localparam NOP_INST
//   - state encoding constants
//  Sub-module pipe_payload_reg: width-parameterised register, async active-high reset, load enable,
//  reset value parameter. Instantiated twice (main, skid).
// TESTING
//  1. Reset release, valid_F=1 pc_F=0x80000000 inst_F=0x00100093, ready_D=1
//     -> next cycle valid_D=1 pc_D=0x80000000 inst_D=0x00100093.
//  2. Streaming 8 instrs pc 0x80000000..0x8000001C with ready_D=1
//     -> ready_F stays 1; 8 back-to-back deq in order.
//  3. ready_D=0 while sending A,B -> A in main, B in skid, ready_F=0.
//     ready_D=1 -> A then B on consecutive cycles; ready_F=1 after B moves to main.
//  4. FULL state + flush=1 -> next cycle valid_D=0, inst_D=0x00000013, ready_F=1;
//     later deq sees only post-flush pc 0x80000100.
//  5. flush=1 and acc in same cycle -> accepted instr never appears on valid_D.
//  6. IFID_PERF_CNT_EN: 3 stall cycles + 2 flushes -> stall_cnt=3, flush_cnt=2; rst -> both 0.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared types and constants for the fetch->decode pipeline buffer.
// Holds default widths, the decode NOP, the payload struct and the FSM encoding.
package pipe_pkg;

  localparam int DEF_XLEN = 32;
  localparam int DEF_ILEN = 32;
  localparam logic [31:0] NOP_INST = 32'h00000013;

  typedef struct packed {
    logic [DEF_ILEN-1:0] inst;
    logic [DEF_XLEN-1:0] pc;
    logic [DEF_XLEN-1:0] pcplus4;
  } if_id_payload_t;

  // Encoding is {main valid, skid valid}; 2'b01 cannot occur.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'b00,
    ST_ONE   = 2'b10,
    ST_FULL  = 2'b11
  } fd_state_e;

endpackage

// File: rtl/buffer_f_d_skid_if.sv
// Fetch/decode handshake bundle: fetch-side input, decode-side output, flush redirect.
// master = the environment around the buffer, slave = the buffer itself.
interface buffer_f_d_skid_if #(
  parameter int XLEN = pipe_pkg::DEF_XLEN,
  parameter int ILEN = pipe_pkg::DEF_ILEN
);
  logic            valid_F;
  logic            ready_F;
  logic [ILEN-1:0] inst_F;
  logic [XLEN-1:0] pc_F;
  logic [XLEN-1:0] pcplus4_F;
  logic            valid_D;
  logic            ready_D;
  logic [ILEN-1:0] inst_D;
  logic [XLEN-1:0] pc_D;
  logic [XLEN-1:0] pcplus4_D;
  logic            flush;

  modport master (
    output valid_F, inst_F, pc_F, pcplus4_F, ready_D, flush,
    input  ready_F, valid_D, inst_D, pc_D, pcplus4_D
  );

  modport slave (
    input  valid_F, inst_F, pc_F, pcplus4_F, ready_D, flush,
    output ready_F, valid_D, inst_D, pc_D, pcplus4_D
  );
endinterface

// File: rtl/pipe_payload_reg.sv
// Load-enabled payload register with asynchronous active-high reset to RST_VAL.
module pipe_payload_reg #(
  parameter int               WIDTH   = 8,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);
  logic [WIDTH-1:0] data_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q <= RST_VAL;
    end else if (load_i) begin
      data_q <= d_i;
    end
  end

  assign q_o = data_q;
endmodule

// File: rtl/buffer_f_d_skid.sv
// Two-entry (main + skid) fetch->decode skid buffer; every output comes from a flop.
// Define IFID_PERF_CNT_EN to add the stall_cnt / flush_cnt performance counters.
module buffer_f_d_skid
  import pipe_pkg::*;
#(
  parameter int XLEN = DEF_XLEN,
  parameter int ILEN = DEF_ILEN
) (
  input  logic                clk,
  input  logic                rst,
  buffer_f_d_skid_if.slave    bus
`ifdef IFID_PERF_CNT_EN
  ,
  output logic [31:0]         stall_cnt,
  output logic [31:0]         flush_cnt
`endif
);
  localparam int              PW       = ILEN + 2 * XLEN;
  localparam logic [ILEN-1:0] NOP_W    = ILEN'(NOP_INST);
  localparam logic [PW-1:0]   MAIN_RST = {NOP_W, {(2 * XLEN){1'b0}}};

  fd_state_e     state_q, state_d;
  logic          acc, deq;
  logic          main_load, skid_load;
  logic [PW-1:0] in_word, main_d, main_q, skid_q;

  assign in_word = {bus.inst_F, bus.pc_F, bus.pcplus4_F};
  assign acc     = bus.valid_F & bus.ready_F;
  assign deq     = bus.valid_D & bus.ready_D;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  // Going empty reloads the NOP so inst_D never shows a stale instruction.
  always_comb begin
    state_d   = state_q;
    main_load = 1'b0;
    skid_load = 1'b0;
    main_d    = in_word;
    if (bus.flush) begin
      state_d   = ST_EMPTY;
      main_load = 1'b1;
      main_d    = MAIN_RST;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (acc) begin
            state_d   = ST_ONE;
            main_load = 1'b1;
          end
        end
        ST_ONE: begin
          if (acc && deq) begin
            main_load = 1'b1;
          end else if (acc) begin
            state_d   = ST_FULL;
            skid_load = 1'b1;
          end else if (deq) begin
            state_d   = ST_EMPTY;
            main_load = 1'b1;
            main_d    = MAIN_RST;
          end
        end
        ST_FULL: begin
          if (deq) begin
            state_d   = ST_ONE;
            main_load = 1'b1;
            main_d    = skid_q;
          end
        end
        default: state_d = ST_EMPTY;
      endcase
    end
  end

  pipe_payload_reg #(.WIDTH(PW), .RST_VAL(MAIN_RST)) u_main (
    .clk    (clk),
    .rst    (rst),
    .load_i (main_load),
    .d_i    (main_d),
    .q_o    (main_q)
  );

  pipe_payload_reg #(.WIDTH(PW), .RST_VAL('0)) u_skid (
    .clk    (clk),
    .rst    (rst),
    .load_i (skid_load),
    .d_i    (in_word),
    .q_o    (skid_q)
  );

  assign bus.valid_D = state_q[1];
  assign bus.ready_F = ~state_q[0];
  assign {bus.inst_D, bus.pc_D, bus.pcplus4_D} = main_q;

`ifdef IFID_PERF_CNT_EN
  logic [31:0] stall_cnt_q, flush_cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (bus.valid_D && !bus.ready_D) begin
        stall_cnt_q <= stall_cnt_q + 32'd1;
      end
      if (bus.flush) begin
        flush_cnt_q <= flush_cnt_q + 32'd1;
      end
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_buffer_f_d_skid.sv
// Bench for buffer_f_d_skid: queue model checked every cycle plus directed literal checks.
module tb_buffer_f_d_skid;
  import pipe_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;

  buffer_f_d_skid_if bus ();

`ifdef IFID_PERF_CNT_EN
  logic [31:0] stall_cnt, flush_cnt;
  buffer_f_d_skid dut (.clk(clk), .rst(rst), .bus(bus), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt));
`else
  buffer_f_d_skid dut (.clk(clk), .rst(rst), .bus(bus));
`endif

  always #5 clk = ~clk;

  // Model: FIFO of held entries (at most two), emptied by flush or reset.
  if_id_payload_t mq[$];
  logic [31:0]    stall_m, flush_m;

  always @(posedge clk or posedge rst) begin : model
    logic           acc_m, deq_m;
    if_id_payload_t p;
    if (rst) begin
      mq.delete();
      stall_m = 0;
      flush_m = 0;
    end else begin
      acc_m = bus.valid_F && (mq.size() < 2);
      deq_m = (mq.size() > 0) && bus.ready_D;
      if (mq.size() > 0 && !bus.ready_D) stall_m = stall_m + 1;
      if (bus.flush) begin
        flush_m = flush_m + 1;
        mq.delete();
      end else begin
        if (deq_m) void'(mq.pop_front());
        if (acc_m) begin
          p.inst    = bus.inst_F;
          p.pc      = bus.pc_F;
          p.pcplus4 = bus.pcplus4_F;
          mq.push_back(p);
        end
      end
    end
  end

  logic [31:0] log_pc[$];
  int          log_cyc[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic compare_model();
    logic [31:0] exp_inst;
    exp_inst = (mq.size() > 0) ? mq[0].inst : NOP_INST;
    chk("m_valid_D", {31'd0, bus.valid_D}, {31'd0, mq.size() > 0});
    chk("m_ready_F", {31'd0, bus.ready_F}, {31'd0, mq.size() < 2});
    chk("m_inst_D", bus.inst_D, exp_inst);
    if (mq.size() > 0) begin
      chk("m_pc_D", bus.pc_D, mq[0].pc);
      chk("m_pcplus4_D", bus.pcplus4_D, mq[0].pcplus4);
    end
`ifdef IFID_PERF_CNT_EN
    chk("m_stall_cnt", stall_cnt, stall_m);
    chk("m_flush_cnt", flush_cnt, flush_m);
`endif
  endtask

  // Inputs are set after a negedge; one clock edge, then compare at the next negedge.
  task automatic tick();
    if (bus.valid_D && bus.ready_D) begin
      log_pc.push_back(bus.pc_D);
      log_cyc.push_back(cyc);
      $display("deq cycle=%0d pc=%h inst=%h", cyc, bus.pc_D, bus.inst_D);
    end
    @(posedge clk);
    @(negedge clk);
    cyc++;
    compare_model();
  endtask

  task automatic drive(input logic v, input logic [31:0] pc, input logic [31:0] inst);
    bus.valid_F   = v;
    bus.pc_F      = pc;
    bus.pcplus4_F = pc + 32'd4;
    bus.inst_F    = inst;
  endtask

  task automatic clear_log();
    log_pc.delete();
    log_cyc.delete();
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_valid_D"}, {31'd0, bus.valid_D}, 32'd0);
    chk({tag, "_ready_F"}, {31'd0, bus.ready_F}, 32'd1);
    chk({tag, "_inst_D"}, bus.inst_D, 32'h00000013);
    chk({tag, "_pc_D"}, bus.pc_D, 32'd0);
  endtask

  logic [2:0] mix [16] = '{3'b110, 3'b100, 3'b100, 3'b010, 3'b111, 3'b100, 3'b101, 3'b011,
                          3'b110, 3'b100, 3'b000, 3'b110, 3'b001, 3'b110, 3'b010, 3'b010};

  initial begin
    drive(1'b0, 32'd0, 32'd0);
    bus.ready_D = 1'b0;
    bus.flush   = 1'b0;
    tick();
    tick();
    chk_reset_vals("reset");
    chk("reset_pcplus4_D", bus.pcplus4_D, 32'd0);
    rst = 1'b0;

    // 1: single instruction, one-cycle latency
    drive(1'b1, 32'h80000000, 32'h00100093);
    bus.ready_D = 1'b1;
    tick();
    chk("t1_valid_D", {31'd0, bus.valid_D}, 32'd1);
    chk("t1_pc_D", bus.pc_D, 32'h80000000);
    chk("t1_inst_D", bus.inst_D, 32'h00100093);
    chk("t1_pcplus4_D", bus.pcplus4_D, 32'h80000004);
    drive(1'b0, 32'd0, 32'd0);
    tick();

    // 2: streaming 8 instructions at full rate
    clear_log();
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 32'h80000000 + 32'(4 * i), 32'h00000093 | (32'(i) << 20));
      tick();
      chk("t2_ready_F", {31'd0, bus.ready_F}, 32'd1);
    end
    drive(1'b0, 32'd0, 32'd0);
    tick();
    tick();
    chk("t2_deq_count", log_pc.size(), 32'd8);
    for (int i = 0; i < log_pc.size(); i++) begin
      chk("t2_deq_pc", log_pc[i], 32'h80000000 + 32'(4 * i));
      if (i > 0) chk("t2_deq_gap", 32'(log_cyc[i] - log_cyc[i-1]), 32'd1);
    end

    // 3: stall fills main and skid, then drains in order
    bus.ready_D = 1'b0;
    drive(1'b1, 32'h80000040, 32'h00a00093);
    tick();
    drive(1'b1, 32'h80000044, 32'h00b00093);
    tick();
    drive(1'b1, 32'h80000048, 32'h00c00093);
    chk("t3_pc_D_A", bus.pc_D, 32'h80000040);
    chk("t3_ready_F_full", {31'd0, bus.ready_F}, 32'd0);
    tick();
    chk("t3_hold_pc_D", bus.pc_D, 32'h80000040);
    drive(1'b0, 32'd0, 32'd0);
    clear_log();
    bus.ready_D = 1'b1;
    tick();
    chk("t3_pc_D_B", bus.pc_D, 32'h80000044);
    chk("t3_ready_F_after", {31'd0, bus.ready_F}, 32'd1);
    tick();
    chk("t3_empty", {31'd0, bus.valid_D}, 32'd0);
    chk("t3_deq_count", log_pc.size(), 32'd2);
    if (log_pc.size() == 2) begin
      chk("t3_first", log_pc[0], 32'h80000040);
      chk("t3_second", log_pc[1], 32'h80000044);
      chk("t3_gap", 32'(log_cyc[1] - log_cyc[0]), 32'd1);
    end

    // 4: flush while full drops both entries
    bus.ready_D = 1'b0;
    drive(1'b1, 32'h80000080, 32'h00d00093);
    tick();
    drive(1'b1, 32'h80000084, 32'h00e00093);
    tick();
    drive(1'b0, 32'd0, 32'd0);
    chk("t4_full", {31'd0, bus.ready_F}, 32'd0);
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    chk("t4_valid_D", {31'd0, bus.valid_D}, 32'd0);
    chk("t4_inst_D", bus.inst_D, 32'h00000013);
    chk("t4_ready_F", {31'd0, bus.ready_F}, 32'd1);
    clear_log();
    bus.ready_D = 1'b1;
    drive(1'b1, 32'h80000100, 32'h00f00093);
    tick();
    drive(1'b0, 32'd0, 32'd0);
    tick();
    tick();
    chk("t4_deq_count", log_pc.size(), 32'd1);
    if (log_pc.size() == 1) chk("t4_deq_pc", log_pc[0], 32'h80000100);

    // 5: an accept in the flush cycle is discarded (from empty and from one entry)
    clear_log();
    drive(1'b1, 32'h80000200, 32'h01000093);
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    drive(1'b0, 32'd0, 32'd0);
    chk("t5_valid_D_empty", {31'd0, bus.valid_D}, 32'd0);
    bus.ready_D = 1'b0;
    drive(1'b1, 32'h80000300, 32'h01100093);
    tick();
    drive(1'b1, 32'h80000304, 32'h01200093);
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    drive(1'b0, 32'd0, 32'd0);
    chk("t5_valid_D_one", {31'd0, bus.valid_D}, 32'd0);
    bus.ready_D = 1'b1;
    tick();
    tick();
    chk("t5_deq_count", log_pc.size(), 32'd0);

    // Mixed directed pattern {valid_F, ready_D, flush}, checked by the model each cycle
    for (int k = 0; k < 16; k++) begin
      drive(mix[k][2], 32'h80000400 + 32'(4 * k), 32'h02000093 + 32'(k));
      bus.ready_D = mix[k][1];
      bus.flush   = mix[k][0];
      tick();
    end
    drive(1'b0, 32'd0, 32'd0);
    bus.flush = 1'b0;

    // Asynchronous reset while full takes effect before the next edge
    bus.ready_D = 1'b0;
    drive(1'b1, 32'h80000500, 32'h03000093);
    tick();
    drive(1'b1, 32'h80000504, 32'h03100093);
    tick();
    drive(1'b0, 32'd0, 32'd0);
    rst = 1'b1;
    #1;
    chk_reset_vals("arst");
    rst = 1'b0;
    tick();

`ifdef IFID_PERF_CNT_EN
    // 6: three stall cycles and two flushes, then reset clears both counters
    rst = 1'b1;
    #1;
    rst = 1'b0;
    chk("t6_stall_zero", stall_cnt, 32'd0);
    chk("t6_flush_zero", flush_cnt, 32'd0);
    bus.ready_D = 1'b0;
    drive(1'b1, 32'h80000600, 32'h04000093);
    tick();
    drive(1'b0, 32'd0, 32'd0);
    tick();
    tick();
    tick();
    bus.ready_D = 1'b1;
    tick();
    bus.flush = 1'b1;
    tick();
    tick();
    bus.flush = 1'b0;
    chk("t6_stall_cnt", stall_cnt, 32'd3);
    chk("t6_flush_cnt", flush_cnt, 32'd2);
    rst = 1'b1;
    #1;
    chk("t6_stall_rst", stall_cnt, 32'd0);
    chk("t6_flush_rst", flush_cnt, 32'd0);
    rst = 1'b0;
    tick();
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
